// File: rtl/music_box_state_controller_if.sv
// Mode-sequencer bus: button and completion inputs from the front panel and state
// modules, plus the shared currentState broadcast and debug word.
interface music_box_state_controller_if;
  logic [3:0]  buttonPulse;
  logic [3:0]  stateComplete;
  logic [4:0]  currentState;
  logic        stateChanged;
  logic [31:0] debugString;

  modport master (
    input  buttonPulse,
    input  stateComplete,
    output currentState,
    output stateChanged,
    output debugString
  );

  modport slave (
    output buttonPulse,
    output stateComplete,
    input  currentState,
    input  stateChanged,
    input  debugString
  );
endinterface

// File: rtl/music_box_state_controller.sv
// Music box mode sequencer: one-cycle registered latency from inputs to all outputs.
// No backpressure; buttons arriving during the post-exit hold-off are dropped.
module music_box_state_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd1_500_000_000,
  parameter int unsigned HOLDOFF_CYCLES = 2
) (
  input  logic                        clock_50Mhz,
  input  logic                        reset,
  music_box_state_controller_if.master bus
);

  localparam int unsigned HoldW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLDOFF_CYCLES);
  localparam logic [31:0] WdLast = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [4:0] {
    ST_IDLE    = 5'd0,
    ST_SONG0   = 5'd1,
    ST_SONG1   = 5'd2,
    ST_RECORD  = 5'd3,
    ST_PLAYREC = 5'd4
  } state_e;

  state_e           state_q, state_d;
  logic             changed_q;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [31:0]      wd_q, wd_d;
  logic [7:0]       entries_q, entries_d;
  logic             timeout_q, timeout_d;
  logic             cancel_q, cancel_d;
  logic             exit_c;
  logic [1:0]       act_idx;

  always_ff @(posedge clock_50Mhz or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      changed_q <= 1'b0;
      hold_q    <= '0;
      wd_q      <= '0;
      entries_q <= '0;
      timeout_q <= 1'b0;
      cancel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      changed_q <= (state_d != state_q);
      hold_q    <= hold_d;
      wd_q      <= wd_d;
      entries_q <= entries_d;
      timeout_q <= timeout_d;
      cancel_q  <= cancel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    wd_d      = wd_q;
    entries_d = entries_q;
    timeout_d = timeout_q;
    cancel_d  = cancel_q;
    exit_c    = 1'b0;
    act_idx   = 2'(state_q - 5'd1);

    case (state_q)
      ST_IDLE: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (bus.buttonPulse != 4'b0000) begin
          if (bus.buttonPulse[0])      state_d = ST_SONG0;
          else if (bus.buttonPulse[1]) state_d = ST_SONG1;
          else if (bus.buttonPulse[2]) state_d = ST_RECORD;
          else                         state_d = ST_PLAYREC;
          entries_d = entries_q + 8'd1;
          wd_d      = '0;
        end
      end
      default: begin
        // Saturate so a disabled watchdog can never wrap into a false expiry.
        if (wd_q != '1) wd_d = wd_q + 32'd1;
        if (bus.stateComplete[act_idx]) begin
          exit_c    = 1'b1;
          timeout_d = 1'b0;
          cancel_d  = 1'b0;
        end else if (bus.buttonPulse[act_idx]) begin
          exit_c    = 1'b1;
          timeout_d = 1'b0;
          cancel_d  = 1'b1;
        end else if ((TIMEOUT_CYCLES != 0) && (wd_q == WdLast)) begin
          exit_c    = 1'b1;
          timeout_d = 1'b1;
          cancel_d  = 1'b0;
        end
      end
    endcase

    if (exit_c) begin
      state_d = ST_IDLE;
      hold_d  = HoldLoad;
    end
  end

  assign bus.currentState = state_q;
  assign bus.stateChanged = changed_q;
  assign bus.debugString  = {14'd0, cancel_q, timeout_q, entries_q, 3'd0, state_q};

endmodule

// File: tb/tb_music_box_state_controller.sv
// Bench for the music box sequencer: vector table, hand-written corner sequences
// and random stimulus against a cycle-level reference model.
module tb_music_box_state_controller;

  localparam int TO = 10;
  localparam int HO = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  music_box_state_controller_if bus ();

  music_box_state_controller #(
    .TIMEOUT_CYCLES(TO),
    .HOLDOFF_CYCLES(HO)
  ) dut (
    .clock_50Mhz(clk),
    .reset(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Reference model: what the user sees, tracked as plain integers.
  int m_state, m_hold, m_dwell, m_entries, m_to, m_cn, m_chg;

  function automatic void model_reset();
    m_state = 0; m_hold = 0; m_dwell = 0; m_entries = 0; m_to = 0; m_cn = 0; m_chg = 0;
  endfunction

  function automatic void model_step(input logic [3:0] b, input logic [3:0] c);
    int prev;
    int tgt;
    prev = m_state;
    if (m_state == 0) begin
      if (m_hold > 0) begin
        m_hold = m_hold - 1;
      end else if (b != 4'b0000) begin
        tgt = 0;
        for (int i = 3; i >= 0; i--) if (b[i]) tgt = i + 1;
        m_state = tgt;
        m_entries = (m_entries + 1) % 256;
        m_dwell = 0;
      end
    end else begin
      m_dwell = m_dwell + 1;
      if (c[m_state-1]) begin
        m_state = 0; m_to = 0; m_cn = 0;
      end else if (b[m_state-1]) begin
        m_state = 0; m_to = 0; m_cn = 1;
      end else if (TO > 0 && m_dwell == TO) begin
        m_state = 0; m_to = 1; m_cn = 0;
      end
      if (m_state == 0) m_hold = HO;
    end
    m_chg = (m_state != prev) ? 1 : 0;
  endfunction

  function automatic logic [31:0] model_dbg();
    logic [31:0] d;
    d = 32'd0;
    d[4:0]   = 5'(m_state);
    d[15:8]  = 8'(m_entries);
    d[16]    = (m_to != 0);
    d[17]    = (m_cn != 0);
    return d;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".state"}, 32'(bus.currentState), 32'(m_state));
    check({tag, ".changed"}, 32'(bus.stateChanged), 32'(m_chg));
    check({tag, ".debug"}, bus.debugString, model_dbg());
  endtask

  // Inputs change at the falling edge, outputs are checked at the next falling edge.
  task automatic tick(input logic [3:0] b, input logic [3:0] c, input string tag);
    bus.buttonPulse = b;
    bus.stateComplete = c;
    @(posedge clk);
    model_step(b, c);
    @(negedge clk);
    check_model(tag);
  endtask

  typedef struct {
    logic [3:0]  b;
    logic [3:0]  c;
    logic [4:0]  st;
    logic        chg;
    logic [31:0] dbg;
  } vec_t;

  vec_t vecs[21];
  int   n_act;

  initial begin
    vecs[0]  = '{4'b0100, 4'b0000, 5'd3, 1'b1, 32'h0000_0103};
    vecs[1]  = '{4'b0000, 4'b0000, 5'd3, 1'b0, 32'h0000_0103};
    vecs[2]  = '{4'b0000, 4'b0100, 5'd0, 1'b1, 32'h0000_0100};
    vecs[3]  = '{4'b0000, 4'b0000, 5'd0, 1'b0, 32'h0000_0100};
    vecs[4]  = '{4'b0000, 4'b0000, 5'd0, 1'b0, 32'h0000_0100};
    vecs[5]  = '{4'b1010, 4'b0000, 5'd2, 1'b1, 32'h0000_0202};
    vecs[6]  = '{4'b0000, 4'b1101, 5'd2, 1'b0, 32'h0000_0202};
    vecs[7]  = '{4'b0000, 4'b0010, 5'd0, 1'b1, 32'h0000_0200};
    vecs[8]  = '{4'b0001, 4'b0000, 5'd0, 1'b0, 32'h0000_0200};
    vecs[9]  = '{4'b0001, 4'b0000, 5'd0, 1'b0, 32'h0000_0200};
    vecs[10] = '{4'b0001, 4'b0000, 5'd1, 1'b1, 32'h0000_0301};
    vecs[11] = '{4'b0010, 4'b0000, 5'd1, 1'b0, 32'h0000_0301};
    vecs[12] = '{4'b0001, 4'b0000, 5'd0, 1'b1, 32'h0002_0300};
    vecs[13] = '{4'b0000, 4'b0000, 5'd0, 1'b0, 32'h0002_0300};
    vecs[14] = '{4'b0000, 4'b0000, 5'd0, 1'b0, 32'h0002_0300};
    vecs[15] = '{4'b0010, 4'b0000, 5'd2, 1'b1, 32'h0002_0402};
    vecs[16] = '{4'b0010, 4'b0010, 5'd0, 1'b1, 32'h0000_0400};
    vecs[17] = '{4'b0000, 4'b0000, 5'd0, 1'b0, 32'h0000_0400};
    vecs[18] = '{4'b0000, 4'b0000, 5'd0, 1'b0, 32'h0000_0400};
    vecs[19] = '{4'b0010, 4'b0000, 5'd2, 1'b1, 32'h0000_0502};
    vecs[20] = '{4'b0010, 4'b0000, 5'd0, 1'b1, 32'h0002_0500};

    bus.buttonPulse = 4'b0000;
    bus.stateComplete = 4'b0000;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset.state", 32'(bus.currentState), 32'd0);
    check("reset.changed", 32'(bus.stateChanged), 32'd0);
    check("reset.debug", bus.debugString, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      tick(vecs[i].b, vecs[i].c, $sformatf("vec%0d.model", i));
      check($sformatf("vec%0d.state", i), 32'(bus.currentState), 32'(vecs[i].st));
      check($sformatf("vec%0d.changed", i), 32'(bus.stateChanged), 32'(vecs[i].chg));
      check($sformatf("vec%0d.debug", i), bus.debugString, vecs[i].dbg);
    end

    // Watchdog: state 4 must be visible for exactly TO cycles.
    tick(4'b0000, 4'b0000, "to.hold0");
    tick(4'b0000, 4'b0000, "to.hold1");
    tick(4'b1000, 4'b0000, "to.enter");
    n_act = (bus.currentState == 5'd4) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      tick(4'b0000, 4'b0000, "to.dwell");
      if (bus.currentState == 5'd4) n_act++;
      else break;
    end
    check("to.dwell_cycles", 32'(n_act), 32'(TO));
    check("to.flags", 32'(bus.debugString[17:16]), 32'd1);

    // Entry counter wraps after 256 entries from reset.
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      tick(4'b0001, 4'b0000, "wrap.enter");
      tick(4'b0001, 4'b0000, "wrap.cancel");
      tick(4'b0000, 4'b0000, "wrap.h0");
      tick(4'b0000, 4'b0000, "wrap.h1");
    end
    check("wrap.count", 32'(bus.debugString[15:8]), 32'd0);

    // Reset asserted between edges clears outputs without a clock edge.
    tick(4'b0100, 4'b0000, "areset.enter");
    #2 rst = 1'b1;
    #1;
    check("areset.state", 32'(bus.currentState), 32'd0);
    check("areset.changed", 32'(bus.stateChanged), 32'd0);
    check("areset.debug", bus.debugString, 32'd0);
    model_reset();
    bus.buttonPulse = 4'b0000;
    bus.stateComplete = 4'b0000;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      logic [3:0] rb;
      logic [3:0] rc;
      rb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      rc = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
      tick(rb, rc, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/music_box_state_controller.md
# music_box_state_controller

Top-level mode sequencer for the music box. Accepts one-cycle button pulses, drives the shared `currentState` bus that every state module (PlaySong0, PlaySong1, RecordSong, PlayRecording) watches, and returns to DoNothing when the active module raises its `stateComplete`. It also handles user cancel, a watchdog timeout and a post-exit hold-off.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1_500_000_000 (30 s at 50 MHz): maximum dwell in any active state. 0 disables the watchdog.
- `HOLDOFF_CYCLES`, default 2: number of cycles DoNothing ignores buttons after any exit from an active state.

Ports:
- `clock_50Mhz` in 1: the only clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `buttonPulse` in 4: debounced single-cycle press pulses. Bit i requests state i+1.
- `stateComplete` in 4: bit i is driven by the module owning state i+1.
- `currentState` out 5: 0 = DoNothing, 1..4 = active states. Values 5..31 are never driven.
- `stateChanged` out 1: one-cycle pulse in the first cycle `currentState` holds a new value.
- `debugString` out 32:
  - [4:0] `currentState`
  - [7:5] 0
  - [15:8] count of entries into active states, 8-bit, wraps 255→0
  - [16] last exit was a timeout
  - [17] last exit was a cancel
  - [31:18] 0

## Operation
- Reset (asynchronous assert) forces:
  - `currentState`=0, `stateChanged`=0, `debugString`=0
  - hold-off counter=0, so buttons are accepted immediately after reset release
  - watchdog counter=0
- DoNothing (state 0), hold-off counter = 0:
  - If any `buttonPulse` bit is set, go to state i+1, where i is the lowest set bit (bit 0 has highest priority).
  - Increment the entry count and clear the watchdog counter.
  - No bits set: stay.
- DoNothing, hold-off counter > 0: decrement by one per cycle. Buttons are dropped, not queued.
- Active state s (1..4), exit conditions:
  - `stateComplete[s-1]`=1 → 0 (normal exit; clear `debugString`[17:16]).
  - `buttonPulse[s-1]`=1 → 0 (cancel; set [17], clear [16]).
  - Watchdog expiry → 0 (timeout; set [16], clear [17]).
- Active state, ignored inputs: other `stateComplete` bits and other `buttonPulse` bits. Active-to-active transitions never occur.
- Priority when several exit conditions occur in the same cycle: complete > cancel > timeout. Only the winning cause's flag is recorded.
- Every exit from an active state loads the hold-off counter with HOLDOFF_CYCLES.
- Watchdog: the counter increments every cycle while active. With TIMEOUT_CYCLES=N>0, `currentState` reads s for exactly N cycles before returning to 0, unless another exit occurs earlier.
- Arithmetic:
  - Watchdog counter is 32-bit, never wraps; compare against N-1.
  - Hold-off counter is sized with `$clog2(HOLDOFF_CYCLES+1)`. HOLDOFF_CYCLES=0 means no hold-off.
- `stateChanged` is registered: high on exactly the cycles where `currentState` differs from its value in the previous cycle.

## Timing
- Input-to-output latency is 1 cycle. Inputs are sampled at edge k; `currentState` and `stateChanged` update at edge k (visible in cycle k+1). There are no combinational input→output paths.
- State modules see `currentState`≠s for at least 1+HOLDOFF_CYCLES cycles between consecutive activations. They use this window to reset themselves.
- `stateComplete` may be held high for multiple cycles. Only the first sampled cycle has effect; later cycles occur in state 0 and are ignored.
- Reset asserted mid-state: `currentState` goes to 0 immediately (asynchronously), without waiting for a clock edge. No exit flags are set, and the count clears.
- `debugString` updates in the same edge as `currentState`.

## Test plan
- Reset release, then `buttonPulse`=4'b0100 for 1 cycle → next cycle `currentState`=3, `stateChanged`=1 for 1 cycle, `debugString`[15:8]=1.
- Simultaneous pulse 4'b1010 in DoNothing → `currentState`=2 (lowest bit wins). In state 2, pulse `stateComplete`=4'b1101 → no change. Then `stateComplete`=4'b0010 → `currentState`=0, [17:16]=0.
- HOLDOFF_CYCLES=2: exit state 1, then pulse `buttonPulse`=4'b0001 in each of the next 3 cycles → only the third pulse is accepted. `currentState`=1 appears 4 cycles after the exit edge.
- TIMEOUT_CYCLES=10, enter state 4, no complete → `currentState`=4 for exactly 10 cycles, then 0 with [16]=1, [17]=0.
- In state 2, `stateComplete[1]` and `buttonPulse[1]` in the same cycle → exit to 0 with [17:16]=00. Repeat with the cancel alone → [17]=1.
- Assert `reset` asynchronously mid-cycle in state 3 after 256 entries → all outputs 0 before the next edge. Separately, 256 entries without reset → [15:8] wraps to 0.
